// File: rtl/rr_chan_mux.sv
// Round-robin multiplexer: NCH per-channel FIFOs feeding one registered output.
// Optional per-channel grant counters are enabled by defining RR_CHAN_MUX_STATS_EN.
module rr_chan_mux #(
    parameter int NCH   = 4,
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           in_valid,
    input  logic [NCH*W-1:0]         in_data,
    output logic [NCH-1:0]           in_ready,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic [$clog2(NCH)-1:0]   out_chan,
    input  logic                     out_ready
`ifdef RR_CHAN_MUX_STATS_EN
    ,
    output logic [NCH*16-1:0]        grant_cnt
`endif
);

    localparam int CW = $clog2(NCH);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    logic [W-1:0]  mem      [NCH][DEPTH];
    logic [AW-1:0] wr_ptr   [NCH];
    logic [AW-1:0] rd_ptr   [NCH];
    logic [AW:0]   cnt      [NCH];

    logic [NCH-1:0] push;
    logic [NCH-1:0] pop_vec;
    logic [NCH-1:0] nonempty;
    logic [CW-1:0]  last_grant;
    logic [CW-1:0]  sel;
    logic [CW-1:0]  idx;
    logic           found;
    logic           loadable;
    logic           pop;
    state_t         state;

    // FIFO status: ready depends only on stored count, never on a same-cycle pop
    always_comb begin
        in_ready = '0;
        nonempty = '0;
        push     = '0;
        for (int c = 0; c < NCH; c++) begin
            in_ready[c] = (cnt[c] != FULL);
            nonempty[c] = (cnt[c] != '0);
            push[c]     = in_valid[c] && (cnt[c] != FULL);
        end
    end

    // Round-robin search starting just after the last granted channel
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = CW'((int'(last_grant) + i) % NCH);
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        loadable = (state == EMPTY) || out_ready;
        pop      = loadable && found;
        pop_vec  = '0;
        for (int c = 0; c < NCH; c++) begin
            pop_vec[c] = pop && (sel == CW'(c));
        end
    end

    // FIFO storage writes (contents need no reset; pointers define validity)
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) begin
                mem[c][wr_ptr[c]] <= in_data[c*W +: W];
            end
        end
    end

    // FIFO pointers and counts; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                cnt[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (push[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + 1'b1;
                end
                if (pop_vec[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
                cnt[c] <= cnt[c] + (AW+1)'(push[c]) - (AW+1)'(pop_vec[c]);
            end
        end
    end

    // Output stage FSM: loads a word when empty or when the held word is taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_chan   <= '0;
            last_grant <= CW'(NCH - 1);
        end else begin
            unique case (state)
                EMPTY: begin
                    if (pop) begin
                        state      <= HOLD;
                        out_data   <= mem[sel][rd_ptr[sel]];
                        out_chan   <= sel;
                        last_grant <= sel;
                    end
                end
                HOLD: begin
                    if (pop) begin
                        out_data   <= mem[sel][rd_ptr[sel]];
                        out_chan   <= sel;
                        last_grant <= sel;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_valid = (state == HOLD);

`ifdef RR_CHAN_MUX_STATS_EN
    logic [15:0] gcnt [NCH];

    // Per-channel count of words accepted by the consumer, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                gcnt[c] <= '0;
            end
        end else if (out_valid && out_ready) begin
            gcnt[out_chan] <= gcnt[out_chan] + 16'd1;
        end
    end

    // Flatten the counters onto the output bus
    always_comb begin
        grant_cnt = '0;
        for (int c = 0; c < NCH; c++) begin
            grant_cnt[c*16 +: 16] = gcnt[c];
        end
    end
`endif

endmodule

// File: doc/rr_chan_mux.md
RR_CHAN_MUX -- requirements
Module: rr_chan_mux

Interface
REQ-001 Parameter NCH, default 4, number of input channels; legal range 2..16.
REQ-002 Parameter W, default 8, data width per channel; legal range 1..64.
REQ-003 Parameter DEPTH, default 4, entries per channel FIFO; power of two, at least 2.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port in_valid, input, NCH bits: per-channel write request.
REQ-007 Port in_data, input, NCH*W bits: channel c occupies bits [c*W +: W].
REQ-008 Port in_ready, output, NCH bits: per-channel FIFO not full.
REQ-009 Port out_valid, output, 1 bit: output register holds a word.
REQ-010 Port out_data, output, W bits: output word.
REQ-011 Port out_chan, output, $clog2(NCH) bits: source channel of out_data.
REQ-012 Port out_ready, input, 1 bit: consumer accepts the word.
REQ-013 Port grant_cnt, output, NCH*16 bits: per-channel accepted-word counters; present only under RR_CHAN_MUX_STATS_EN.

Function
REQ-014 Push on channel c SHALL occur when in_valid[c] and in_ready[c] are both 1 at a rising edge.
REQ-015 in_ready[c] SHALL be 1 exactly when FIFO c holds fewer than DEPTH words, with no dependence on same-cycle pops.
REQ-016 Each FIFO SHALL be first-in first-out with wrapping read and write pointers and a count of width $clog2(DEPTH)+1.
REQ-017 There SHALL be no bypass: a pushed word becomes visible to the arbiter on the cycle after the push.
REQ-018 Minimum latency from push edge to out_valid high SHALL be 2 cycles.
REQ-019 The output stage SHALL have two states, EMPTY (out_valid=0) and HOLD (out_valid=1).
REQ-020 The output stage SHALL be loadable when it is in EMPTY, or in HOLD with out_ready=1.
REQ-021 When loadable and any FIFO is non-empty, the arbiter SHALL pop one FIFO, load out_data and out_chan, and enter or remain in HOLD.
REQ-022 Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NCH, and the first non-empty channel wins.
REQ-023 If HOLD has out_ready=1 and all FIFOs are empty, the output stage SHALL go to EMPTY.
REQ-024 If HOLD has out_ready=0, out_valid, out_data and out_chan SHALL stay stable and no pop SHALL occur.
REQ-025 Back-to-back transfers SHALL sustain one word per cycle while any FIFO is non-empty and out_ready=1.
REQ-026 A push and a pop on the same channel in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-027 last_grant SHALL update only when a pop occurs.

Reset
REQ-028 While rst_n=0 at a rising edge, all FIFO counts and pointers SHALL become 0, the output stage SHALL enter EMPTY, and last_grant SHALL become NCH-1 (so channel 0 has first priority).
REQ-029 During reset, outputs SHALL be: out_valid=0, out_data=0, out_chan=0, in_ready all 1, and grant_cnt all 0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered words and the held word, with no partial state retained.

Configuration
REQ-031 With macro RR_CHAN_MUX_STATS_EN defined, grant_cnt[c*16 +: 16] SHALL increment on each out_valid&&out_ready with out_chan=c, wrapping from 16'hFFFF to 0.
REQ-032 Without RR_CHAN_MUX_STATS_EN, the grant_cnt port and its counter logic SHALL be absent, with all other behaviour identical.

Verification
REQ-033 Single word: push 8'hA5 on ch2 at cycle 0 with out_ready=1 -> out_valid=1, out_data=A5, out_chan=2 at cycle 2 only.
REQ-034 Fairness: all 4 channels hold 3 words each, out_ready=1 -> out_chan sequence 0,1,2,3,0,1,2,3,0,1,2,3 with no idle cycle.
REQ-035 Full/backpressure: out_ready=0, push 5 words on ch1 -> in_ready[1]=0 after 4 words are stored plus 1 held; the 6th push is refused; data order is preserved on release.
REQ-036 Stall: hold out_ready=0 for 10 cycles in HOLD -> out_data/out_chan stay constant; FIFO counts change only by pushes.
REQ-037 Reset mid-operation: assert rst_n=0 with 3 words buffered -> next cycle out_valid=0 and in_ready=4'hF; the first grant after release goes to ch0.
REQ-038 Stats (macro on): 65537 transfers on ch0 -> grant_cnt[15:0]=1 and other counters 0.
